sevseg_scan_ctrl: RTL and testbench
===================================

Name: sevseg_scan_ctrl

Overview:
Scan controller and frame buffer for the 4-digit seven-segment display. It holds a double-buffered frame of four 7-bit segment patterns, written by upstream logic through a valid/ready port. It drives the active frame and the digit select into the 4:1 segment mux, and generates one-hot digit enables with an inter-digit blanking gap to suppress ghosting. New frames go live only at frame boundaries, so the display never shows a torn frame.

Parameters:
PRESCALE, 1000, clock cycles per digit slot; legal range >= 2.
BLANK, 16, cycles at the start of each slot with all digit enables off; legal range 0..PRESCALE-1, 0 disables blanking.

Ports:
i_clk  input  1  clock, the single clock domain.
i_rst_n  input  1  asynchronous active-low reset.
i_en  input  1  scan enable; when low, counters hold and o_an = 0.
i_wr_valid  input  1  write request to the shadow frame.
i_wr_addr  input  2  digit index to write (0..3).
i_wr_data  input  7  segment pattern for that digit.
o_wr_ready  output  1  write accepted when i_wr_valid & o_wr_ready.
i_commit  input  1  single-cycle request to promote the shadow frame to active.
o_commit_pending  output  1  commit requested, swap not yet done.
o_dig0..o_dig3  output  7 each  active frame, to the mux data inputs 0..3.
o_sel  output  2  current digit index, to the mux select.
o_an  output  4  one-hot digit enable, active high.
o_frame_start  output  1  one-cycle pulse when o_sel wraps to 0.

Behaviour:
- Reset (asynchronous, i_rst_n low), all registers cleared:
  - cnt = 0, o_sel = 0, o_an = 0.
  - Active and shadow frames = 7'b0000000.
  - o_commit_pending = 0, o_frame_start = 0, o_wr_ready = 1.
- Prescaler:
  - When i_en = 1, cnt counts 0..PRESCALE-1.
  - At cnt = PRESCALE-1, cnt goes to 0 and o_sel increments modulo 4 (3 wraps to 0).
  - When i_en = 0, cnt and o_sel hold.
- Frame boundary: the cycle where i_en = 1, cnt = PRESCALE-1 and o_sel = 3.
  - o_frame_start = 1 in the following cycle (o_sel = 0, cnt = 0), otherwise 0.
- Digit enables:
  - o_an is registered and always consistent with the current cnt and o_sel.
  - o_an = (i_en_q && cnt >= BLANK) ? (1 << o_sel) : 4'b0000, where i_en_q is i_en registered.
  - o_an is never multi-hot.
  - When BLANK = 0, o_an is continuously one-hot while enabled.
- Write port:
  - o_wr_ready = ~o_commit_pending; the shadow frame is frozen while a commit is pending.
  - On accept, shadow[i_wr_addr] <= i_wr_data.
  - A write presented while not ready is held by the upstream until accepted, not dropped.
- Commit:
  - i_commit with o_commit_pending = 0 sets pending on the next edge.
  - i_commit while pending is ignored (no queueing).
  - A write accepted in the same cycle as i_commit is included in the committed frame.
  - At a frame boundary with pending = 1: active <= shadow, pending <= 0, and o_wr_ready returns high the next cycle.
  - A commit arriving exactly in a boundary cycle sets pending and swaps at the next boundary, one full frame later.
  - With i_en = 0 no boundary occurs, so pending persists.
  - The shadow frame retains its contents after a swap; it is not cleared.
- Outputs o_dig0..3 change only at reset or on a swap. Latency from swap to visibility is 0 relative to the new o_sel = 0.
- Reset mid-frame or mid-commit: everything returns to reset values immediately. A pending commit is discarded.

Decomposition:
- Shared package sevseg_pkg:
  - SEG_W = 7, NDIG = 4, SEL_W = 2.
  - SEG_BLANK = 7'b0000000.
  - Type seg_t = logic [SEG_W-1:0].
- One sub-module, sevseg_prescaler:
  - Parameter PRESCALE; inputs i_clk, i_rst_n, i_en; outputs cnt and terminal-count pulse o_tc.
  - The top instantiates it and owns o_sel, the frame buffers and the commit logic.

Test Plan:
1. Reset with i_en = 1, PRESCALE = 8, BLANK = 2 -> o_an = 0000 for cnt 0..1, then 0001 for cnt 2..7. o_sel steps 0,1,2,3,0 every 8 cycles. o_frame_start pulses once per 32 cycles.
2. Write addr0..3 = 7'h3F, 7'h06, 7'h5B, 7'h4F, then commit mid-frame -> o_dig* unchanged until the boundary. At o_frame_start, o_dig0..3 = 3F,06,5B,4F and pending clears.
3. Commit with pending high -> o_wr_ready = 0. A write to addr1 = 7'h7F stalls until the swap, and is not present in the swapped frame.
4. Write and commit in the same cycle as the boundary cycle -> pending set. The swap happens 32 cycles later and includes the written value.
5. Drop i_en for 20 cycles mid-slot with pending high -> o_an = 0, cnt/o_sel frozen, no swap. On i_en rise, scanning resumes from the held cnt.
6. Assert reset mid-frame with pending high -> all outputs 0 and o_wr_ready = 1 immediately. After release, scanning restarts at o_sel = 0, cnt = 0.

Source files
------------

// File: rtl/sevseg_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
package sevseg_pkg;

    localparam int SEG_W = 7;
    localparam int NDIG  = 4;
    localparam int SEL_W = 2;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b0000000;

    typedef enum logic {
        CM_IDLE    = 1'b0,
        CM_PENDING = 1'b1
    } commit_state_t;

    function automatic logic [NDIG-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        return NDIG'(1) << sel;
    endfunction

endpackage

// File: rtl/sevseg_prescaler.sv
// Digit-slot prescaler: counts 0..PRESCALE-1 while enabled, flags the last cycle of each slot.
module sevseg_prescaler #(
    parameter int PRESCALE = 1000,
    localparam int CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tc;

    assign w_tc = i_en && (r_cnt == CNT_W'(PRESCALE - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = w_tc;

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// Double-buffered frame store and digit scanner for a 4-digit seven-segment display.
// Shadow writes are frozen while a commit waits for the next frame boundary.
module sevseg_scan_ctrl
    import sevseg_pkg::*;
#(
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_wr_valid,
    input  logic [1:0]       i_wr_addr,
    input  logic [6:0]       i_wr_data,
    output logic             o_wr_ready,
    input  logic             i_commit,
    output logic             o_commit_pending,
    output logic [6:0]       o_dig0,
    output logic [6:0]       o_dig1,
    output logic [6:0]       o_dig2,
    output logic [6:0]       o_dig3,
    output logic [1:0]       o_sel,
    output logic [3:0]       o_an,
    output logic             o_frame_start
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_tc;
    logic             w_boundary;
    logic             w_past_blank;
    logic [SEL_W-1:0] w_sel_next;
    logic             w_wr_fire;
    logic [NDIG-1:0]  w_wr_hit;
    logic             w_swap;

    commit_state_t    r_state;
    commit_state_t    w_state_next;
    logic [SEL_W-1:0] r_sel;
    logic [NDIG-1:0]  r_an;
    logic             r_frame_start;
    seg_t             r_shadow [NDIG];
    seg_t             r_active [NDIG];

    sevseg_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .o_cnt   (w_cnt),
        .o_tc    (w_tc)
    );

    assign w_boundary = w_tc && (r_sel == SEL_W'(NDIG - 1));
    assign w_sel_next = w_tc ? r_sel + 1'b1 : r_sel;
    assign w_cnt_next = !i_en ? w_cnt : (w_tc ? '0 : w_cnt + 1'b1);

    // The enables are registered from next-state values so they line up with cnt/o_sel.
    generate
        if (BLANK == 0) begin : g_no_blank
            assign w_past_blank = 1'b1;
        end else begin : g_blank
            assign w_past_blank = (w_cnt_next >= CNT_W'(BLANK));
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sel         <= '0;
            r_an          <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_sel         <= w_sel_next;
            r_an          <= (i_en && w_past_blank) ? sel_onehot(w_sel_next) : '0;
            r_frame_start <= w_boundary;
        end
    end

    assign w_wr_fire = i_wr_valid && (r_state == CM_IDLE);

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_wr_hit
            assign w_wr_hit[gi] = w_wr_fire && (i_wr_addr == SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= CM_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_swap       = 1'b0;
        case (r_state)
            CM_IDLE: begin
                if (i_commit) begin
                    w_state_next = CM_PENDING;
                end
            end
            CM_PENDING: begin
                if (w_boundary) begin
                    w_swap       = 1'b1;
                    w_state_next = CM_IDLE;
                end
            end
            default: w_state_next = CM_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NDIG; i++) begin
                r_shadow[i] <= SEG_BLANK;
                r_active[i] <= SEG_BLANK;
            end
        end else begin
            for (int i = 0; i < NDIG; i++) begin
                if (w_wr_hit[i]) begin
                    r_shadow[i] <= i_wr_data;
                end
                if (w_swap) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    assign o_wr_ready       = (r_state == CM_IDLE);
    assign o_commit_pending = (r_state == CM_PENDING);
    assign o_dig0           = r_active[0];
    assign o_dig1           = r_active[1];
    assign o_dig2           = r_active[2];
    assign o_dig3           = r_active[3];
    assign o_sel            = r_sel;
    assign o_an             = r_an;
    assign o_frame_start    = r_frame_start;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Self-checking bench for sevseg_scan_ctrl: cycle model of the scanner plus a frame scoreboard.
module tb_sevseg_scan_ctrl;

    localparam int PS = 8;
    localparam int BL = 2;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_en = 1'b0;
    logic       i_wr_valid = 1'b0;
    logic [1:0] i_wr_addr = '0;
    logic [6:0] i_wr_data = '0;
    logic       i_commit = 1'b0;
    logic       o_wr_ready;
    logic       o_commit_pending;
    logic [6:0] o_dig0, o_dig1, o_dig2, o_dig3;
    logic [1:0] o_sel;
    logic [3:0] o_an;
    logic       o_frame_start;

    sevseg_scan_ctrl #(
        .PRESCALE (PS),
        .BLANK    (BL)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_en             (i_en),
        .i_wr_valid       (i_wr_valid),
        .i_wr_addr        (i_wr_addr),
        .i_wr_data        (i_wr_data),
        .o_wr_ready       (o_wr_ready),
        .i_commit         (i_commit),
        .o_commit_pending (o_commit_pending),
        .o_dig0           (o_dig0),
        .o_dig1           (o_dig1),
        .o_dig2           (o_dig2),
        .o_dig3           (o_dig3),
        .o_sel            (o_sel),
        .o_an             (o_an),
        .o_frame_start    (o_frame_start)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model, advanced on the same edges as the DUT.
    int           m_cnt = 0;
    int           m_sel = 0;
    bit           m_enq = 0;
    bit           m_pend = 0;
    bit           m_fs = 0;
    bit           m_swap = 0;
    logic [6:0]   m_shadow [4];
    logic [27:0]  sb_q [$];
    logic [27:0]  exp_active = '0;

    always @(posedge i_clk or negedge i_rst_n) begin
        bit bnd;
        if (!i_rst_n) begin
            m_cnt = 0; m_sel = 0; m_enq = 0; m_pend = 0; m_fs = 0; m_swap = 0;
            for (int i = 0; i < 4; i++) m_shadow[i] = '0;
        end else begin
            bnd = i_en && (m_cnt == PS - 1) && (m_sel == 3);
            if (i_wr_valid && !m_pend) m_shadow[i_wr_addr] = i_wr_data;
            m_fs   = bnd;
            m_swap = bnd && m_pend;
            if (m_swap) begin
                m_pend = 0;
            end else if (i_commit && !m_pend) begin
                m_pend = 1;
                sb_q.push_back({m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]});
            end
            if (i_en) begin
                if (m_cnt == PS - 1) begin
                    m_cnt = 0;
                    m_sel = (m_sel + 1) % 4;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            m_enq = i_en;
        end
    end

    always @(negedge i_clk) begin
        logic [3:0] exp_an;
        if (!i_rst_n) begin
            sb_q.delete();
            exp_active = '0;
        end else if (m_swap) begin
            if (sb_q.size() == 0) check_eq("sb_underflow", 32'd0, 32'd1);
            else exp_active = sb_q.pop_front();
        end
        exp_an = (m_enq && m_cnt >= BL) ? 4'(1 << m_sel) : 4'b0000;
        check_eq("frame", {o_dig3, o_dig2, o_dig1, o_dig0}, exp_active);
        check_eq("sel", o_sel, m_sel[1:0]);
        check_eq("an", o_an, exp_an);
        check_eq("frame_start", o_frame_start, m_fs);
        check_eq("pending", o_commit_pending, m_pend);
        check_eq("wr_ready", o_wr_ready, !m_pend);
    end

    task automatic wr(input logic [1:0] a, input logic [6:0] d);
        int n = 0;
        i_wr_valid = 1'b1;
        i_wr_addr  = a;
        i_wr_data  = d;
        while (!o_wr_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 200) check_eq("wr_timeout", 32'd0, 32'd1);
        @(negedge i_clk);
        i_wr_valid = 1'b0;
        $display("write addr=%0d data=%02h accepted after %0d stall cycles", a, d, n);
    endtask

    task automatic commit_pulse();
        i_commit = 1'b1;
        @(negedge i_clk);
        i_commit = 1'b0;
        $display("commit issued, pending=%0b", o_commit_pending);
    endtask

    task automatic wait_fs();
        int n = 0;
        @(negedge i_clk);
        while (!o_frame_start && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 100) check_eq("fs_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_pos(input int c, input int s);
        int n = 0;
        while (!(m_cnt == c && m_sel == s) && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 200) check_eq("align_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [1:0] held_sel;
        repeat (3) @(negedge i_clk);
        i_en    = 1'b1;
        i_rst_n = 1'b1;

        // Plain scanning across more than one frame.
        repeat (40) @(negedge i_clk);
        $display("scan: sel=%0d an=%b", o_sel, o_an);

        // Load a frame and commit mid-frame.
        wr(2'd0, 7'h3F); wr(2'd1, 7'h06); wr(2'd2, 7'h5B); wr(2'd3, 7'h4F);
        commit_pulse();
        check_eq("t2_pending", o_commit_pending, 1'b1);
        wait_fs();
        check_eq("t2_dig0", o_dig0, 7'h3F);
        check_eq("t2_dig1", o_dig1, 7'h06);
        check_eq("t2_dig2", o_dig2, 7'h5B);
        check_eq("t2_dig3", o_dig3, 7'h4F);
        check_eq("t2_pend_clr", o_commit_pending, 1'b0);
        $display("swap: dig=%02h %02h %02h %02h", o_dig0, o_dig1, o_dig2, o_dig3);

        // Write stalls while a commit is pending and misses that frame.
        commit_pulse();
        check_eq("t3_ready_low", o_wr_ready, 1'b0);
        wr(2'd1, 7'h7F);
        check_eq("t3_dig1_excl", o_dig1, 7'h06);

        // Write and commit in the boundary cycle: swap lands one frame later.
        wait_pos(PS - 1, 3);
        i_wr_valid = 1'b1; i_wr_addr = 2'd2; i_wr_data = 7'h11; i_commit = 1'b1;
        @(negedge i_clk);
        i_wr_valid = 1'b0; i_commit = 1'b0;
        check_eq("t4_pending", o_commit_pending, 1'b1);
        check_eq("t4_fs", o_frame_start, 1'b1);
        check_eq("t4_dig2_old", o_dig2, 7'h5B);
        repeat (31) @(negedge i_clk);
        check_eq("t4_dig2_wait", o_dig2, 7'h5B);
        @(negedge i_clk);
        check_eq("t4_fs2", o_frame_start, 1'b1);
        check_eq("t4_dig2_new", o_dig2, 7'h11);
        check_eq("t4_dig1_new", o_dig1, 7'h7F);
        $display("boundary commit: dig=%02h %02h %02h %02h", o_dig0, o_dig1, o_dig2, o_dig3);

        // Scan enable dropped with a commit pending.
        wait_pos(2, 1);
        wr(2'd3, 7'h22);
        commit_pulse();
        i_en = 1'b0;
        held_sel = o_sel;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            check_eq("t5_an_off", o_an, 4'b0000);
            check_eq("t5_sel_held", o_sel, held_sel);
            check_eq("t5_pend_held", o_commit_pending, 1'b1);
        end
        i_en = 1'b1;
        wait_fs();
        check_eq("t5_dig3", o_dig3, 7'h22);
        check_eq("t5_pend_clr", o_commit_pending, 1'b0);
        $display("resume: dig3=%02h", o_dig3);

        // Reset in the middle of a pending commit.
        wait_pos(3, 2);
        wr(2'd0, 7'h55);
        commit_pulse();
        check_eq("t6_pending", o_commit_pending, 1'b1);
        #2 i_rst_n = 1'b0;
        #1;
        check_eq("t6_an", o_an, 4'b0000);
        check_eq("t6_sel", o_sel, 2'd0);
        check_eq("t6_frame", {o_dig3, o_dig2, o_dig1, o_dig0}, 28'd0);
        check_eq("t6_pend", o_commit_pending, 1'b0);
        check_eq("t6_ready", o_wr_ready, 1'b1);
        check_eq("t6_fs", o_frame_start, 1'b0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_eq("t6_restart_sel", o_sel, 2'd0);
        repeat (40) @(negedge i_clk);
        $display("after reset: sel=%0d an=%b", o_sel, o_an);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
